uart_cmd_scheduler: RTL and testbench
=====================================

// Module: uart_cmd_scheduler
// PURPOSE
//  Sits between the car's command sources and the UART link to the simulated car.
//  Arbitrates between a manual-drive requester and an auto-drive requester, and emits one
//  command frame per FRAME_PERIOD through the UART transmitter's start/busy handshake.
//  Latches detector feedback from received frames and forces a safe stop on link loss.
// PARAMETERS
//  FRAME_PERIOD  100000    sys_clk cycles between frame ticks (1 ms @ 100 MHz); must be >= 2
//  RX_TIMEOUT    5000000   cycles without rx_valid before link_lost asserts
//  CNT_W         24        width of frame and timeout counters; must hold both parameters
// PORTS
//  sys_clk    in   1  system clock, 100 MHz
//  rst        in   1  synchronous, active-high reset
//  enable     in   1  high while the car is powered on; low stops issuing new frames
//  man_req    in   1  manual requester has a command pending
//  man_cmd    in   6  {destroy,place,right,left,back,fwd}
//  man_ack    out  1  1-cycle pulse: man_cmd latched into a frame
//  auto_req   in   1  auto requester has a command pending
//  auto_cmd   in   6  same encoding as man_cmd
//  auto_ack   out  1  1-cycle pulse: auto_cmd latched into a frame
//  tx_busy    in   1  UART transmitter busy
//  tx_start   out  1  request transmission of tx_data
//  tx_data    out  8  frame byte {2'b10, cmd[5:0]}
//  rx_valid   in   1  1-cycle strobe: rx_data holds a newly received byte
//  rx_data    in   8  received byte; [3:0] = {right,left,back,front} detectors
//  detectors  out  4  {right,left,back,front}, latched
//  link_lost  out  1  no rx_valid for RX_TIMEOUT cycles
//  grant_src  out  2  source of the last frame: 00 idle, 01 manual, 10 auto
// BEHAVIOUR
//  Reset values:
//   - man_ack = auto_ack = tx_start = 0; tx_data = 8'h80.
//   - detectors = 0; link_lost = 0; grant_src = 00.
//   - FSM = IDLE; frame counter = 0; timeout counter = 0; pending = 0.
//  Frame counter:
//   - Counts 0..FRAME_PERIOD-1 and wraps. tick = 1 on the cycle the count equals FRAME_PERIOD-1.
//   - Counter is held at 0 while enable = 0.
//  pending flag:
//   - Set on tick; cleared on entry to ARB.
//   - A tick while pending is already set is dropped, so at most one frame is owed.
//  FSM states: IDLE -> ARB -> SEND -> WAIT_BUSY -> WAIT_DONE -> IDLE.
//   - IDLE: go to ARB when pending && enable.
//   - ARB (1 cycle), selection in priority order:
//     * man_req: cmd = man_cmd, man_ack = 1, grant_src = 01.
//     * else auto_req: cmd = auto_cmd, auto_ack = 1, grant_src = 10.
//     * else: cmd = 0, grant_src = 00.
//     * Requesters drop one-shot barrier bits after their ack; this block never repeats an acked cmd.
//   - SEND: tx_data = {2'b10, cmd}, tx_start = 1.
//     * tx_start stays high until tx_busy is sampled 1, then -> WAIT_BUSY.
//   - WAIT_BUSY: tx_start = 0; wait for tx_busy = 0, then -> IDLE.
//     * WAIT_DONE is merged into WAIT_BUSY; only 4 states are encoded.
//  Sanitising, applied in ARB after source selection:
//   - fwd & back both set -> both cleared.
//   - left & right both set -> both cleared.
//   - link_lost = 1 -> cmd forced to 6'b0 (tx_data = 8'h80). The requester is still acked.
//  enable falling:
//   - A frame in SEND or WAIT_BUSY runs to completion.
//   - pending is cleared and no further ARB entry occurs.
//  Receive path and link timeout:
//   - On rx_valid with rx_data[7:6] == 2'b10: detectors <= rx_data[3:0] and the timeout counter resets.
//   - Bytes with any other header are ignored and do not reset the timeout counter.
//   - Timeout counter saturates at RX_TIMEOUT. link_lost = 1 while the count equals RX_TIMEOUT.
//   - While link_lost = 1, detectors read 4'hF (all blocked).
//   - link_lost clears on the cycle after the next valid rx byte.
//  Latency: 2 cycles from pending in IDLE to tx_start high. Ack is a 1-cycle pulse in ARB.
//  rst = 1 at any point: all state returns to reset values on that edge; an in-flight frame is abandoned.
// TESTING
//  1. FRAME_PERIOD = 10, no requests, tx_busy pulsed 3 cycles after tx_start.
//     -> a tx_data = 8'h80 frame every 10 cycles; grant_src = 00.
//  2. man_req and auto_req both set, man_cmd = 6'h01, auto_cmd = 6'h02.
//     -> man_ack pulses, tx_data = 8'h81, grant_src = 01, auto_ack stays 0.
//  3. auto_cmd = 6'h0F with man_req = 0.
//     -> fwd/back and left/right conflicts cleared, tx_data = 8'h80, auto_ack = 1.
//  4. tx_busy held high for 25 cycles with FRAME_PERIOD = 10.
//     -> exactly one owed frame follows completion; the extra tick is dropped.
//  5. RX_TIMEOUT = 50, no rx_valid.
//     -> link_lost = 1 at cycle 50; detectors = 4'hF; frames carry 8'h80.
//     -> then rx_data = 8'h85 -> link_lost = 0, detectors = 4'h5.
//  6. rst asserted while in WAIT_BUSY -> next cycle all outputs at reset values; state IDLE.

Source files
------------

// File: rtl/uart_cmd_scheduler.sv
// Frame scheduler for the car UART link: arbitrates manual/auto command sources once per
// frame tick, sanitises the chosen command, and tracks detector feedback and link health.
module uart_cmd_scheduler #(
  parameter int unsigned FRAME_PERIOD = 100000,
  parameter int unsigned RX_TIMEOUT   = 5000000,
  parameter int unsigned CNT_W        = 24
) (
  input  logic       sys_clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       man_req_i,
  input  logic [5:0] man_cmd_i,
  output logic       man_ack_o,
  input  logic       auto_req_i,
  input  logic [5:0] auto_cmd_i,
  output logic       auto_ack_o,
  input  logic       tx_busy_i,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  output logic [3:0] detectors_o,
  output logic       link_lost_o,
  output logic [1:0] grant_src_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARB       = 2'd1,
    SEND      = 2'd2,
    WAIT_BUSY = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_PERIOD - 1);
  localparam logic [CNT_W-1:0] RX_LIMIT   = CNT_W'(RX_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic             pending_q, pending_d;
  logic [5:0]       cmd_q, cmd_d;
  logic [1:0]       grant_q, grant_d;
  logic [3:0]       det_q, det_d;

  logic       tick;
  logic       arb_enter;
  logic       rx_ok;
  logic       link_lost;
  logic [5:0] sel_cmd;
  logic [5:0] san_cmd;
  logic       unused_rx_bits;

  assign unused_rx_bits = ^rx_data_i[5:4];

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      rx_cnt_q    <= '0;
      pending_q   <= 1'b0;
      cmd_q       <= '0;
      grant_q     <= 2'b00;
      det_q       <= 4'h0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      pending_q   <= pending_d;
      cmd_q       <= cmd_d;
      grant_q     <= grant_d;
      det_q       <= det_d;
    end
  end

  // Frame counter only runs while powered; tick marks the last count of each period.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    tick        = 1'b0;
    if (!enable_i) begin
      frame_cnt_d = '0;
    end else if (frame_cnt_q == FRAME_LAST) begin
      frame_cnt_d = '0;
      tick        = 1'b1;
    end else begin
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end
  end

  // At most one frame is owed: a tick arriving while pending is set is simply absorbed.
  always_comb begin
    pending_d = pending_q;
    if (arb_enter || !enable_i) begin
      pending_d = 1'b0;
    end else if (tick) begin
      pending_d = 1'b1;
    end
  end

  // Handshake with the transmitter: tx_start is held high with tx_data stable until
  // tx_busy is sampled high (byte accepted); the next frame waits until tx_busy drops.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    grant_d    = grant_q;
    man_ack_o  = 1'b0;
    auto_ack_o = 1'b0;
    tx_start_o = 1'b0;
    arb_enter  = 1'b0;
    sel_cmd    = 6'b0;
    case (state_q)
      IDLE: begin
        if (pending_q && enable_i) begin
          state_d   = ARB;
          arb_enter = 1'b1;
        end
      end
      ARB: begin
        if (man_req_i) begin
          sel_cmd   = man_cmd_i;
          man_ack_o = 1'b1;
          grant_d   = 2'b01;
        end else if (auto_req_i) begin
          sel_cmd    = auto_cmd_i;
          auto_ack_o = 1'b1;
          grant_d    = 2'b10;
        end else begin
          grant_d = 2'b00;
        end
        cmd_d   = san_cmd;
        state_d = SEND;
      end
      SEND: begin
        tx_start_o = 1'b1;
        if (tx_busy_i) begin
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!tx_busy_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Contradictory motion pairs cancel; a lost link always sends the all-stop command.
  always_comb begin
    san_cmd = sel_cmd;
    if (san_cmd[0] && san_cmd[1]) begin
      san_cmd[1:0] = 2'b00;
    end
    if (san_cmd[2] && san_cmd[3]) begin
      san_cmd[3:2] = 2'b00;
    end
    if (link_lost) begin
      san_cmd = 6'b0;
    end
  end

  assign rx_ok     = rx_valid_i && (rx_data_i[7:6] == 2'b10);
  assign link_lost = (rx_cnt_q == RX_LIMIT);

  always_comb begin
    det_d    = det_q;
    rx_cnt_d = rx_cnt_q;
    if (rx_ok) begin
      det_d    = rx_data_i[3:0];
      rx_cnt_d = '0;
    end else if (!link_lost) begin
      rx_cnt_d = rx_cnt_q + CNT_W'(1);
    end
  end

  assign tx_data_o   = {2'b10, cmd_q};
  assign grant_src_o = grant_q;
  assign link_lost_o = link_lost;
  assign detectors_o = link_lost ? 4'hF : det_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_uart_cmd_scheduler.sv
// Bench for uart_cmd_scheduler: vector table of arbitration cases checked through a frame
// scoreboard, plus hand-written sequences for owed frames, link loss, enable drop and reset.
`timescale 1ns/1ps
module tb_uart_cmd_scheduler;
  localparam int FP  = 10;
  localparam int RXT = 50;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARB  = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  typedef struct {
    logic       mreq;
    logic [5:0] mcmd;
    logic       areq;
    logic [5:0] acmd;
    logic [7:0] exp_data;
    logic [1:0] exp_grant;
    logic       exp_mack;
    logic       exp_aack;
  } vec_t;

  logic       sys_clk, rst, enable, man_req, auto_req, tx_busy, rx_valid;
  logic [5:0] man_cmd, auto_cmd;
  logic       man_ack, auto_ack, tx_start, link_lost;
  logic [7:0] tx_data, rx_data;
  logic [3:0] detectors;
  logic [1:0] grant_src, state;

  logic       busy_auto, busy_resp, busy_force;
  logic       ka_en, ka_valid, m_valid;
  logic [3:0] ka_det;
  logic [7:0] m_data;

  int         tests_run;
  int         tests_failed;
  logic [9:0] exp_q[$];
  vec_t       vecs[8];

  assign tx_busy  = busy_resp | busy_force;
  assign rx_valid = ka_valid | m_valid;
  assign rx_data  = m_valid ? m_data : {4'b1000, ka_det};

  uart_cmd_scheduler #(
    .FRAME_PERIOD(FP),
    .RX_TIMEOUT  (RXT),
    .CNT_W       (8)
  ) dut (
    .sys_clk_i  (sys_clk),
    .rst_i      (rst),
    .enable_i   (enable),
    .man_req_i  (man_req),
    .man_cmd_i  (man_cmd),
    .man_ack_o  (man_ack),
    .auto_req_i (auto_req),
    .auto_cmd_i (auto_cmd),
    .auto_ack_o (auto_ack),
    .tx_busy_i  (tx_busy),
    .tx_start_o (tx_start),
    .tx_data_o  (tx_data),
    .rx_valid_i (rx_valid),
    .rx_data_i  (rx_data),
    .detectors_o(detectors),
    .link_lost_o(link_lost),
    .grant_src_o(grant_src),
    .state_o    (state)
  );

  // clock / reset
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // transmitter model: raises busy 3 cycles after a start, for 2 cycles
  initial begin
    busy_resp = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (busy_auto && tx_start) begin
        repeat (3) @(negedge sys_clk);
        busy_resp = 1'b1;
        repeat (2) @(negedge sys_clk);
        busy_resp = 1'b0;
      end
    end
  end

  // car model: periodic valid feedback byte
  initial begin
    ka_valid = 1'b0;
    forever begin
      repeat (20) @(negedge sys_clk);
      if (ka_en) begin
        ka_valid = 1'b1;
        @(negedge sys_clk);
        ka_valid = 1'b0;
      end
    end
  end

  // scoreboard: each expected frame is compared when its tx_start rises
  initial begin
    logic       prev;
    logic [9:0] e;
    prev = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (tx_start && !prev && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("frame_data", {24'b0, tx_data}, {24'b0, e[7:0]});
        check("frame_grant", {30'b0, grant_src}, {30'b0, e[9:8]});
      end
      prev = tx_start;
    end
  end

  task automatic wait_state(input logic [1:0] s, input string name);
    int n;
    n = 0;
    while (state !== s && n < 40) begin
      @(negedge sys_clk);
      n++;
    end
    if (state !== s) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s: timeout, state %0d required %0d", name, state, s);
    end
  endtask

  task automatic count_arb(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge sys_clk);
      if (state == S_ARB) cnt++;
    end
  endtask

  task automatic arb_gap(output int n);
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (state !== S_ARB && n < 40);
  endtask

  task automatic do_frame(input vec_t v, input int idx);
    man_req  = v.mreq;
    man_cmd  = v.mcmd;
    auto_req = v.areq;
    auto_cmd = v.acmd;
    wait_state(S_ARB, $sformatf("vec%0d_arb", idx));
    if (state == S_ARB) begin
      check($sformatf("vec%0d_man_ack", idx), {31'b0, man_ack}, {31'b0, v.exp_mack});
      check($sformatf("vec%0d_auto_ack", idx), {31'b0, auto_ack}, {31'b0, v.exp_aack});
      exp_q.push_back({v.exp_grant, v.exp_data});
      @(negedge sys_clk);
      man_req  = 1'b0;
      auto_req = 1'b0;
      check($sformatf("vec%0d_tx_start", idx), {31'b0, tx_start}, 32'd1);
      check($sformatf("vec%0d_ack_pulse", idx), {30'b0, man_ack, auto_ack}, 32'd0);
    end
    wait_state(S_IDLE, $sformatf("vec%0d_done", idx));
  endtask

  initial begin
    int n;
    tests_run    = 0;
    tests_failed = 0;
    rst        = 1'b1;
    enable     = 1'b0;
    man_req    = 1'b0;
    man_cmd    = 6'h0;
    auto_req   = 1'b0;
    auto_cmd   = 6'h0;
    busy_auto  = 1'b1;
    busy_force = 1'b0;
    ka_en      = 1'b0;
    ka_det     = 4'h3;
    m_valid    = 1'b0;
    m_data     = 8'h00;

    vecs[0] = '{1'b1, 6'h01, 1'b1, 6'h02, 8'h81, 2'b01, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 6'h00, 1'b1, 6'h0F, 8'h80, 2'b10, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 6'h3F, 1'b0, 6'h00, 8'hB0, 2'b01, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 6'h00, 1'b1, 6'h25, 8'hA5, 2'b10, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 6'h00, 1'b0, 6'h00, 8'h80, 2'b00, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 6'h07, 1'b0, 6'h00, 8'h84, 2'b01, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 6'h0A, 1'b1, 6'h01, 8'h8A, 2'b01, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 6'h00, 1'b1, 6'h1C, 8'h90, 2'b10, 1'b0, 1'b1};

    // reset values
    repeat (3) @(negedge sys_clk);
    check("rst_state", {30'b0, state}, {30'b0, S_IDLE});
    check("rst_tx_start", {31'b0, tx_start}, 32'd0);
    check("rst_tx_data", {24'b0, tx_data}, 32'h80);
    check("rst_acks", {30'b0, man_ack, auto_ack}, 32'd0);
    check("rst_detectors", {28'b0, detectors}, 32'd0);
    check("rst_link_lost", {31'b0, link_lost}, 32'd0);
    check("rst_grant", {30'b0, grant_src}, 32'd0);
    rst    = 1'b0;
    ka_en  = 1'b1;
    enable = 1'b1;

    // idle frames: first ARB 11 cycles after enable, then one every FRAME_PERIOD
    exp_q.push_back({2'b00, 8'h80});
    exp_q.push_back({2'b00, 8'h80});
    arb_gap(n);
    check("first_arb_latency", n, 32'd11);
    arb_gap(n);
    check("frame_period", n, FP);
    wait_state(S_IDLE, "period_done");

    for (int i = 0; i < 8; i++) begin
      do_frame(vecs[i], i);
    end
    check("detectors_keepalive", {28'b0, detectors}, 32'h3);

    // transmitter stalled 25 cycles: exactly one owed frame afterwards
    wait_state(S_ARB, "hold_arb");
    busy_auto = 1'b0;
    repeat (4) @(negedge sys_clk);
    busy_force = 1'b1;
    repeat (25) @(negedge sys_clk);
    check("hold_in_wait_busy", {30'b0, state}, {30'b0, S_WB});
    busy_force = 1'b0;
    busy_auto  = 1'b1;
    count_arb(10, n);
    check("owed_frame_count", n, 32'd1);
    @(negedge sys_clk);
    check("next_tick_arb", {30'b0, state}, {30'b0, S_ARB});

    // link loss: valid byte, then an ignored header, then silence
    ka_en = 1'b0;
    repeat (3) @(negedge sys_clk);
    m_data  = 8'h86;
    m_valid = 1'b1;
    @(negedge sys_clk);
    m_valid = 1'b0;
    repeat (10) @(negedge sys_clk);
    m_data  = 8'h45;
    m_valid = 1'b1;
    @(negedge sys_clk);
    m_valid = 1'b0;
    repeat (38) @(negedge sys_clk);
    check("link_ok_at_49", {31'b0, link_lost}, 32'd0);
    check("detectors_latched", {28'b0, detectors}, 32'h6);
    @(negedge sys_clk);
    check("link_lost_at_50", {31'b0, link_lost}, 32'd1);
    check("detectors_blocked", {28'b0, detectors}, 32'hF);
    do_frame('{1'b1, 6'h01, 1'b0, 6'h00, 8'h80, 2'b01, 1'b1, 1'b0}, 8);
    check("link_still_lost", {31'b0, link_lost}, 32'd1);
    m_data  = 8'h85;
    m_valid = 1'b1;
    @(negedge sys_clk);
    m_valid = 1'b0;
    check("link_recovered", {31'b0, link_lost}, 32'd0);
    check("detectors_recovered", {28'b0, detectors}, 32'h5);
    ka_det = 4'h5;
    ka_en  = 1'b1;

    // enable drops with a frame owed while in WAIT_BUSY
    wait_state(S_IDLE, "enfall_idle");
    wait_state(S_ARB, "enfall_arb");
    busy_auto = 1'b0;
    repeat (2) @(negedge sys_clk);
    busy_force = 1'b1;
    repeat (8) @(negedge sys_clk);
    enable = 1'b0;
    @(negedge sys_clk);
    busy_force = 1'b0;
    busy_auto  = 1'b1;
    wait_state(S_IDLE, "enfall_complete");
    count_arb(30, n);
    check("disabled_no_arb", n, 32'd0);
    enable = 1'b1;
    arb_gap(n);
    check("reenable_latency", n, 32'd11);

    // reset mid-frame
    wait_state(S_IDLE, "rst_idle");
    man_cmd = 6'h21;
    man_req = 1'b1;
    wait_state(S_ARB, "rst_arb");
    @(negedge sys_clk);
    man_req = 1'b0;
    wait_state(S_WB, "rst_wb");
    check("pre_rst_data", {24'b0, tx_data}, 32'hA1);
    rst = 1'b1;
    @(negedge sys_clk);
    check("midrst_state", {30'b0, state}, {30'b0, S_IDLE});
    check("midrst_tx", {23'b0, tx_start, tx_data}, 32'h080);
    check("midrst_grant", {30'b0, grant_src}, 32'd0);
    check("midrst_acks", {30'b0, man_ack, auto_ack}, 32'd0);
    check("midrst_rx", {27'b0, link_lost, detectors}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
